sprite_bram_arbiter: RTL and testbench
======================================

SPRITE_BRAM_ARBITER -- requirements
Module: sprite_bram_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of sprite requesters sharing one sprite BRAM read port.
REQ-002 SHALL have parameter ADR_W, default 18, BRAM address width.
REQ-003 SHALL have parameter BRAM_LATENCY, default 2, clock edges from bram_adr update to valid bram_dout.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port frame_sync  input  1  one-cycle pulse at frame start (vsync).
REQ-007 SHALL have port req  input  NUM_REQ  per-requester read request, level.
REQ-008 SHALL have port req_adr  input  NUM_REQ*ADR_W  packed addresses; requester i at bits [i*ADR_W +: ADR_W].
REQ-009 SHALL have port bram_adr  output  ADR_W  registered BRAM read address.
REQ-010 SHALL have port bram_dout  input  1  BRAM pixel bit.
REQ-011 SHALL have port gnt  output  NUM_REQ  registered one-hot grant, one cycle per accepted request.
REQ-012 SHALL have port rsp_valid  output  NUM_REQ  registered one-hot response strobe.
REQ-013 SHALL have port rsp_data  output  1  registered pixel bit for the rsp_valid requester.
REQ-014 SHALL have port busy  output  1  high while any response is in flight.

Function
REQ-015 SHALL accept at most one request per clock edge; throughput one read per cycle.
REQ-016 SHALL select the winner round-robin: lowest index i >= ptr with req[i]=1, else wrap to lowest index with req[i]=1.
REQ-017 SHALL on a grant to winner w set gnt=onehot(w), bram_adr=req_adr[w], ptr=(w+1) mod NUM_REQ at the same edge.
REQ-018 SHALL with no req bit set drive gnt=0, bram_adr=0, and hold ptr.
REQ-019 SHALL with frame_sync=1 at an edge arbitrate that edge with ptr treated as 0, then update ptr per REQ-017 (ptr=0 if no grant).
REQ-020 SHALL carry the winner index through a BRAM_LATENCY-deep tag/valid shift pipeline.
REQ-021 SHALL for a grant at edge k capture bram_dout into rsp_data and assert rsp_valid=onehot(w) for exactly one cycle from edge k+BRAM_LATENCY.
REQ-022 SHALL keep rsp_valid=0 and hold rsp_data in cycles with no response.
REQ-023 SHALL not drop or reorder responses; back-to-back grants produce back-to-back responses in grant order.
REQ-024 SHALL let a requester deasserting req after its grant still receive its in-flight response.
REQ-025 SHALL assert busy iff any pipeline stage holds a valid tag.
REQ-026 SHALL ignore frame_sync for in-flight responses; they complete normally.
REQ-027 SHALL accept a requester holding req continuously, re-granting it no more than once per NUM_REQ grants while others request.

Reset
REQ-028 SHALL on reset=1 immediately clear gnt, rsp_valid, rsp_data, bram_adr, busy, ptr and all pipeline valid bits, regardless of clock.
REQ-029 SHALL discard in-flight responses on reset; no rsp_valid for them after release.
REQ-030 SHALL grant on the first rising edge with reset=0 and any req set, starting at requester 0.

Verification
REQ-031 SHALL cover: single req[2]=1, adr 0x00123 at edge k -> gnt=4'b0100 and bram_adr=0x00123 after k; rsp_valid=4'b0100, rsp_data=BRAM bit after edge k+2.
REQ-032 SHALL cover: req=4'b1111 held 8 cycles from reset -> gnt sequence 0001,0010,0100,1000,0001,... and responses in same order 2 cycles later.
REQ-033 SHALL cover: ptr=3 (last grant req 2), req=4'b1011 with frame_sync=1 -> gnt=4'b0001, ptr=1 next.
REQ-034 SHALL cover: req=0 for 5 cycles -> gnt=0, bram_adr=0, rsp_valid=0 after pipeline drains, busy=0.
REQ-035 SHALL cover: reset asserted mid-cycle with 2 responses in flight -> all outputs 0 asynchronously, no rsp_valid after release.
REQ-036 SHALL cover: req[1] drops the cycle after its grant -> rsp_valid=4'b0010 still delivered at edge k+2.

Source files
------------

// File: rtl/sprite_bram_arbiter.sv
// Round-robin arbiter sharing one sprite BRAM read port among NUM_REQ requesters.
// One grant per clock edge. The winner index travels down a BRAM_LATENCY-deep
// tag/valid pipeline, so each response comes back to its requester in grant order.
module sprite_bram_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ADR_W        = 18,
    parameter int unsigned BRAM_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_sync,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*ADR_W-1:0] req_adr,
    output logic [ADR_W-1:0]         bram_adr,
    input  logic                     bram_dout,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic                     rsp_data,
    output logic                     busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        base;
    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [ADR_W-1:0]        adr_q, adr_d;
    logic [BRAM_LATENCY-1:0] vld_q;
    logic [IDX_W-1:0]        tag_q [BRAM_LATENCY];
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic                    rsp_data_q, rsp_data_d;

    // Round-robin winner search: first requester at or above the pointer, else
    // wrap to the lowest requester; frame_sync restarts the search at index 0.
    always_comb begin
        base      = frame_sync ? '0 : ptr_q;
        win_found = 1'b0;
        win_idx   = '0;
        adr_d     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req[i] && (i >= 32'(base))) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                adr_d     = req_adr[i*ADR_W +: ADR_W];
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                adr_d     = req_adr[i*ADR_W +: ADR_W];
            end
        end
    end

    // Grant vector and next pointer derived from the winner.
    always_comb begin
        gnt_d = '0;
        ptr_d = frame_sync ? '0 : ptr_q;
        if (win_found) begin
            gnt_d[win_idx] = 1'b1;
            ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    // Response strobe and data from the last pipeline stage; data holds when idle.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (vld_q[BRAM_LATENCY-1]) begin
            rsp_valid_d[tag_q[BRAM_LATENCY-1]] = 1'b1;
            rsp_data_d = bram_dout;
        end
    end

    // Arbiter state: pointer, registered grant and BRAM address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            gnt_q <= '0;
            adr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
            adr_q <= adr_d;
        end
    end

    // Tag/valid shift pipeline tracking reads in flight through the BRAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int unsigned j = 0; j < BRAM_LATENCY; j++) begin
                tag_q[j] <= '0;
            end
        end else begin
            vld_q[0] <= win_found;
            tag_q[0] <= win_idx;
            for (int unsigned j = 1; j < BRAM_LATENCY; j++) begin
                vld_q[j] <= vld_q[j-1];
                tag_q[j] <= tag_q[j-1];
            end
        end
    end

    // Registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign gnt       = gnt_q;
    assign bram_adr  = adr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = |vld_q;

endmodule

// File: tb/tb_sprite_bram_arbiter.sv
// Scoreboard bench for sprite_bram_arbiter: directed request vectors push the
// expected grants and responses into queues; a negedge monitor pops and compares.
module tb_sprite_bram_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_sync;
    logic [3:0]  req;
    logic [71:0] req_adr;
    logic [17:0] bram_adr;
    logic        bram_dout;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic        rsp_data;
    logic        busy;

    logic [17:0] adr_tab [4];
    logic [17:0] adr_d1 = '0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        last_d = 1'b0;

    typedef struct {
        int         edge_n;
        logic [3:0] oh;
        logic [17:0] adr;
        logic       d;
    } exp_t;

    exp_t gq[$];
    exp_t rq[$];

    sprite_bram_arbiter #(
        .NUM_REQ(4),
        .ADR_W(18),
        .BRAM_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_sync(frame_sync),
        .req(req),
        .req_adr(req_adr),
        .bram_adr(bram_adr),
        .bram_dout(bram_dout),
        .gnt(gnt),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: one internal register stage, pixel bit = parity of address.
    always @(posedge clk) adr_d1 <= bram_adr;
    assign bram_dout = ^adr_d1;

    assign req_adr = {adr_tab[3], adr_tab[2], adr_tab[1], adr_tab[0]};

    function automatic logic bram_bit(input logic [17:0] a);
        return ^a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs; w is the hand-computed winner (-1 = none).
    task automatic step(input logic [3:0] r, input bit fs, input int w, input bit pg, input bit pr);
        exp_t e;
        req        = r;
        frame_sync = fs;
        if (w >= 0) begin
            e.edge_n = cyc + 1;
            e.oh     = 4'(1 << w);
            e.adr    = adr_tab[w];
            e.d      = bram_bit(adr_tab[w]);
            if (pg) gq.push_back(e);
            if (pr) begin
                e.edge_n = cyc + 1 + LAT;
                rq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        frame_sync = 1'b0;
    endtask

    // Monitor: compare every presented grant/response against the queues.
    initial begin
        exp_t me;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_d = 1'b0;
            end else begin
                if (gnt != 4'b0) begin
                    if (gq.size() == 0) begin
                        chk("gnt_unexpected", 32'(gnt), 32'h0);
                    end else begin
                        me = gq.pop_front();
                        chk("gnt_cycle", cyc, me.edge_n);
                        chk("gnt", 32'(gnt), 32'(me.oh));
                        chk("bram_adr", 32'(bram_adr), 32'(me.adr));
                    end
                end
                if (rsp_valid != 4'b0) begin
                    if (rq.size() == 0) begin
                        chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
                    end else begin
                        me = rq.pop_front();
                        chk("rsp_cycle", cyc, me.edge_n);
                        chk("rsp_valid", 32'(rsp_valid), 32'(me.oh));
                        chk("rsp_data", 32'(rsp_data), 32'(me.d));
                        last_d = me.d;
                    end
                end else begin
                    chk("rsp_data_hold", 32'(rsp_data), 32'(last_d));
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        frame_sync = 1'b0;
        req        = 4'b0;
        adr_tab[0] = 18'h00010;   // parity 1
        adr_tab[1] = 18'h00A01;   // parity 1
        adr_tab[2] = 18'h00123;   // parity 0
        adr_tab[3] = 18'h2FFFF;   // parity 1

        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_bram_adr", 32'(bram_adr), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;

        // All requesters held: strict rotation starting at 0.
        for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, i % 4, 1'b1, 1'b1);

        // Single requester 2; ptr becomes 3.
        step(4'b0100, 1'b0, 2, 1'b1, 1'b1);
        // frame_sync restarts at 0 while req2's response is in flight; ptr=1.
        step(4'b1011, 1'b1, 0, 1'b1, 1'b1);
        step(4'b1011, 1'b0, 1, 1'b1, 1'b1);
        step(4'b1011, 1'b0, 3, 1'b1, 1'b1);

        // Requester 1 drops right after its grant; response still delivered.
        step(4'b0010, 1'b0, 1, 1'b1, 1'b1);
        step(4'b0000, 1'b0, -1, 1'b0, 1'b0);
        // ptr=2, only req0: wrap-around winner 0; ptr=1.
        step(4'b0001, 1'b0, 0, 1'b1, 1'b1);
        // frame_sync with no request clears ptr to 0, so req 0011 picks 0.
        step(4'b0000, 1'b1, -1, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 0, 1'b1, 1'b1);

        // Idle: no grant, address 0, pipeline drains.
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 1'b0, -1, 1'b0, 1'b0);
            chk("idle_gnt", 32'(gnt), 32'h0);
            chk("idle_bram_adr", 32'(bram_adr), 32'h0);
            if (i >= 2) begin
                chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
                chk("idle_busy", 32'(busy), 32'h0);
            end
        end

        // Two reads in flight, then asynchronous reset mid-cycle (ptr=1).
        step(4'b1111, 1'b0, 1, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 2, 1'b0, 1'b0);
        chk("pre_rst_gnt", 32'(gnt), 32'h4);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        req = 4'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_bram_adr", 32'(bram_adr), 32'h0);
        chk("async_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("async_rsp_data", 32'(rsp_data), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Any stale response would be flagged as unexpected by the monitor.
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, -1, 1'b0, 1'b0);
        chk("post_rst_busy", 32'(busy), 32'h0);

        // First grant after reset starts at requester 0.
        step(4'b1111, 1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, -1, 1'b0, 1'b0);

        chk("gnt_queue_empty", 32'(gq.size()), 32'h0);
        chk("rsp_queue_empty", 32'(rq.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
